// File: rtl/gate_eval_sequencer.sv
// gate_eval_sequencer: evaluates one garbled-circuit gate per descriptor using label_array and an AND core
// Ports: clk, rst (async, active-low); gate_* descriptor handshake in, gate_done/gate_err/gate_count out;
//        mem_* is the sole master port of label_array; and_* is the req/ack port of the external AND core.
module gate_eval_sequencer #(
    parameter int WIRE_W  = 13,
    parameter int LABEL_W = 128,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               gate_valid,
    output logic               gate_ready,
    input  logic [1:0]         gate_op,
    input  logic [WIRE_W-1:0]  gate_in_a,
    input  logic [WIRE_W-1:0]  gate_in_b,
    input  logic [WIRE_W-1:0]  gate_out,
    output logic               gate_done,
    output logic               gate_err,
    output logic [WIRE_W-1:0]  mem_wire_id,
    output logic               mem_id_strobe,
    output logic               mem_wr_en,
    output logic [LABEL_W-1:0] mem_label_in,
    input  logic [LABEL_W-1:0] mem_label_out,
    input  logic               mem_done,
    output logic               and_req,
    output logic [LABEL_W-1:0] and_a,
    output logic [LABEL_W-1:0] and_b,
    output logic [WIRE_W-1:0]  and_gate_id,
    input  logic               and_ack,
    input  logic [LABEL_W-1:0] and_label,
    output logic [CNT_W-1:0]   gate_count
);
    typedef enum logic [2:0] {IDLE, WAIT_A, WAIT_B, AND_WAIT, WAIT_WR, DONE} state_t;
    localparam logic [1:0] OP_XOR = 2'b00, OP_BUF = 2'b01, OP_ILL = 2'b11;
    state_t               state_q;
    logic [1:0]           op_q;
    logic [WIRE_W-1:0]    id_b_q, id_out_q, wire_q;
    logic [LABEL_W-1:0]   lab_a_q, lab_b_q, wdata_q;
    logic                 ready_q, done_q, err_q, strobe_q, wr_q, and_req_q;
    logic [CNT_W-1:0]     cnt_q;
    assign gate_ready    = ready_q;
    assign gate_done     = done_q;
    assign gate_err      = err_q;
    assign mem_wire_id   = wire_q;
    assign mem_id_strobe = strobe_q;
    assign mem_wr_en     = wr_q;
    assign mem_label_in  = wdata_q;
    assign and_req       = and_req_q;
    assign and_a         = lab_a_q;
    assign and_b         = lab_b_q;
    assign and_gate_id   = id_out_q;
    assign gate_count    = cnt_q;
    // Strobe and gate_done default low each cycle so they can only ever pulse for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            op_q      <= OP_XOR;
            id_b_q    <= '0;
            id_out_q  <= '0;
            wire_q    <= '0;
            lab_a_q   <= '0;
            lab_b_q   <= '0;
            wdata_q   <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            strobe_q  <= 1'b0;
            wr_q      <= 1'b0;
            and_req_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: if (gate_valid && ready_q) begin
                    op_q     <= gate_op;
                    id_b_q   <= gate_in_b;
                    id_out_q <= gate_out;
                    ready_q  <= 1'b0;
                    err_q    <= gate_op == OP_ILL;
                    if (gate_op == OP_ILL) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        strobe_q <= 1'b1;
                        wr_q     <= 1'b0;
                        wire_q   <= gate_in_a;
                        state_q  <= WAIT_A;
                    end
                end
                WAIT_A: if (mem_done) begin
                    lab_a_q  <= mem_label_out;
                    strobe_q <= 1'b1;
                    if (op_q == OP_BUF) begin
                        wr_q    <= 1'b1;
                        wire_q  <= id_out_q;
                        wdata_q <= mem_label_out;
                        state_q <= WAIT_WR;
                    end else begin
                        wire_q  <= id_b_q;
                        state_q <= WAIT_B;
                    end
                end
                WAIT_B: if (mem_done) begin
                    lab_b_q <= mem_label_out;
                    if (op_q == OP_XOR) begin
                        strobe_q <= 1'b1;
                        wr_q     <= 1'b1;
                        wire_q   <= id_out_q;
                        wdata_q  <= lab_a_q ^ mem_label_out;
                        state_q  <= WAIT_WR;
                    end else begin
                        and_req_q <= 1'b1;
                        state_q   <= AND_WAIT;
                    end
                end
                AND_WAIT: if (and_ack) begin
                    and_req_q <= 1'b0;
                    strobe_q  <= 1'b1;
                    wr_q      <= 1'b1;
                    wire_q    <= id_out_q;
                    wdata_q   <= and_label;
                    state_q   <= WAIT_WR;
                end
                WAIT_WR: if (mem_done) begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    ready_q <= 1'b1;
                    err_q   <= 1'b0;
                    cnt_q   <= err_q ? cnt_q : cnt_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
